// File: rtl/leve_axir_arb.sv
// Two-requester AXI read arbiter: instruction fetch (I) and data load (D) share one
// memory read port, one transaction outstanding, with RLAST/ARLEN consistency checking.
module leve_axir_arb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DATA_W = 32,
  parameter bit          FIXED  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch requester
  input  logic              i_arvalid_i,
  output logic              i_arready_o,
  input  logic [XLEN-1:0]   i_araddr_i,
  input  logic [7:0]        i_arlen_i,
  output logic              i_rvalid_o,
  input  logic              i_rready_i,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic [1:0]        i_rresp_o,
  output logic              i_rlast_o,
  // data load requester
  input  logic              d_arvalid_i,
  output logic              d_arready_o,
  input  logic [XLEN-1:0]   d_araddr_i,
  input  logic [7:0]        d_arlen_i,
  output logic              d_rvalid_o,
  input  logic              d_rready_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic [1:0]        d_rresp_o,
  output logic              d_rlast_o,
  // memory side
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  output logic [XLEN-1:0]   m_araddr_o,
  output logic [7:0]        m_arlen_o,
  input  logic              m_rvalid_i,
  output logic              m_rready_o,
  input  logic [DATA_W-1:0] m_rdata_i,
  input  logic [1:0]        m_rresp_i,
  input  logic              m_rlast_i,
  // status
  output logic [1:0]        gnt_o,
  output logic              err_o
);

  localparam int unsigned LEN_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             prefer_d_q, prefer_d_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             in_addr;
  logic             in_data;
  logic             ar_hs;
  logic             beat;
  logic             pick_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 2'b00;
      prefer_d_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      prefer_d_q <= prefer_d_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign in_addr = (state_q == S_ADDR);
  assign in_data = (state_q == S_DATA);
  assign ar_hs   = m_arvalid_o & m_arready_i;
  assign beat    = m_rvalid_i & m_rready_o;

  // I wins when alone, under fixed priority, or when it was not the last one served
  assign pick_i  = i_arvalid_i & (~d_arvalid_i | FIXED | ~prefer_d_q);

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    prefer_d_d = prefer_d_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_arvalid_i | d_arvalid_i) begin
          state_d = S_ADDR;
          gnt_d   = pick_i ? 2'b01 : 2'b10;
        end
      end
      S_ADDR: begin
        if (ar_hs) begin
          state_d    = S_DATA;
          cnt_d      = m_arlen_o;
          prefer_d_d = gnt_q[0];
        end
      end
      S_DATA: begin
        if (beat) begin
          cnt_d = cnt_q - LEN_W'(1);
          // RLAST must coincide exactly with the counter reaching zero
          if (m_rlast_i != (cnt_q == '0)) begin
            err_d = 1'b1;
          end
          if (m_rlast_i) begin
            state_d = S_IDLE;
            gnt_d   = 2'b00;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // Combinational routing between the granted requester and memory
  always_comb begin
    m_arvalid_o = 1'b0;
    m_araddr_o  = '0;
    m_arlen_o   = '0;
    m_rready_o  = 1'b0;
    i_arready_o = 1'b0;
    d_arready_o = 1'b0;
    i_rvalid_o  = 1'b0;
    d_rvalid_o  = 1'b0;
    if (in_addr) begin
      if (gnt_q[0]) begin
        m_arvalid_o = i_arvalid_i;
        m_araddr_o  = i_araddr_i;
        m_arlen_o   = i_arlen_i;
        i_arready_o = m_arready_i;
      end else if (gnt_q[1]) begin
        m_arvalid_o = d_arvalid_i;
        m_araddr_o  = d_araddr_i;
        m_arlen_o   = d_arlen_i;
        d_arready_o = m_arready_i;
      end
    end
    if (in_data) begin
      if (gnt_q[0]) begin
        m_rready_o = i_rready_i;
        i_rvalid_o = m_rvalid_i;
      end else if (gnt_q[1]) begin
        m_rready_o = d_rready_i;
        d_rvalid_o = m_rvalid_i;
      end
    end
  end

  // Payload fans out to both; RVALID qualifies it
  assign i_rdata_o = m_rdata_i;
  assign i_rresp_o = m_rresp_i;
  assign i_rlast_o = m_rlast_i;
  assign d_rdata_o = m_rdata_i;
  assign d_rresp_o = m_rresp_i;
  assign d_rlast_o = m_rlast_i;

  assign gnt_o = gnt_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_leve_axir_arb.sv
// Directed bench for leve_axir_arb: a round-robin and a fixed-priority instance share
// the same stimulus; expected values are hand-derived per step.
module tb_leve_axir_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        i_arvalid, i_rready, d_arvalid, d_rready;
  logic [31:0] i_araddr, d_araddr;
  logic [7:0]  i_arlen, d_arlen;
  logic        m_arready, m_rvalid, m_rlast;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;

  // round-robin instance outputs
  logic        i_arready, i_rvalid, i_rlast, d_arready, d_rvalid, d_rlast;
  logic [31:0] i_rdata, d_rdata, m_araddr;
  logic [1:0]  i_rresp, d_rresp, gnt;
  logic        m_arvalid, m_rready, err;
  logic [7:0]  m_arlen;

  // fixed-priority instance outputs
  logic        f_i_arready, f_i_rvalid, f_i_rlast, f_d_arready, f_d_rvalid, f_d_rlast;
  logic [31:0] f_i_rdata, f_d_rdata, f_m_araddr;
  logic [1:0]  f_i_rresp, f_d_rresp, f_gnt;
  logic        f_m_arvalid, f_m_rready, f_err;
  logic [7:0]  f_m_arlen;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  leve_axir_arb #(.XLEN(32), .DATA_W(32), .FIXED(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .i_arvalid_i(i_arvalid), .i_arready_o(i_arready), .i_araddr_i(i_araddr), .i_arlen_i(i_arlen),
    .i_rvalid_o(i_rvalid), .i_rready_i(i_rready), .i_rdata_o(i_rdata), .i_rresp_o(i_rresp),
    .i_rlast_o(i_rlast),
    .d_arvalid_i(d_arvalid), .d_arready_o(d_arready), .d_araddr_i(d_araddr), .d_arlen_i(d_arlen),
    .d_rvalid_o(d_rvalid), .d_rready_i(d_rready), .d_rdata_o(d_rdata), .d_rresp_o(d_rresp),
    .d_rlast_o(d_rlast),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr), .m_arlen_o(m_arlen),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp),
    .m_rlast_i(m_rlast),
    .gnt_o(gnt), .err_o(err)
  );

  leve_axir_arb #(.XLEN(32), .DATA_W(32), .FIXED(1'b1)) u_fx (
    .clk(clk), .rst(rst),
    .i_arvalid_i(i_arvalid), .i_arready_o(f_i_arready), .i_araddr_i(i_araddr), .i_arlen_i(i_arlen),
    .i_rvalid_o(f_i_rvalid), .i_rready_i(i_rready), .i_rdata_o(f_i_rdata), .i_rresp_o(f_i_rresp),
    .i_rlast_o(f_i_rlast),
    .d_arvalid_i(d_arvalid), .d_arready_o(f_d_arready), .d_araddr_i(d_araddr), .d_arlen_i(d_arlen),
    .d_rvalid_o(f_d_rvalid), .d_rready_i(d_rready), .d_rdata_o(f_d_rdata), .d_rresp_o(f_d_rresp),
    .d_rlast_o(f_d_rlast),
    .m_arvalid_o(f_m_arvalid), .m_arready_i(m_arready), .m_araddr_o(f_m_araddr),
    .m_arlen_o(f_m_arlen),
    .m_rvalid_i(m_rvalid), .m_rready_o(f_m_rready), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp),
    .m_rlast_i(m_rlast),
    .gnt_o(f_gnt), .err_o(f_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    i_arvalid = 1'b0; i_araddr = '0; i_arlen = '0; i_rready = 1'b0;
    d_arvalid = 1'b0; d_araddr = '0; d_arlen = '0; d_rready = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    clear_inputs();
    settle();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    cyc();
    rst = 1'b0;
  endtask

  // One length-0 transaction with both requesters held valid; caller is in IDLE
  task automatic round(input logic [1:0] exp_rr, input logic [31:0] data);
    cyc();
    m_arready = 1'b1;
    settle();
    chk("rnd_gnt_rr", 64'(gnt), 64'(exp_rr));
    chk("rnd_gnt_fx", 64'(f_gnt), 64'd1);
    chk("rnd_araddr_rr", 64'(m_araddr), exp_rr[0] ? 64'h1000 : 64'h2000);
    chk("rnd_i_arready_rr", 64'(i_arready), 64'(exp_rr[0]));
    chk("rnd_d_arready_rr", 64'(d_arready), 64'(exp_rr[1]));
    chk("rnd_d_arready_fx", 64'(f_d_arready), 64'd0);
    cyc();
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = data; m_rlast = 1'b1;
    settle();
    chk("rnd_i_rvalid_rr", 64'(i_rvalid), 64'(exp_rr[0]));
    chk("rnd_d_rvalid_rr", 64'(d_rvalid), 64'(exp_rr[1]));
    chk("rnd_d_rvalid_fx", 64'(f_d_rvalid), 64'd0);
    chk("rnd_rdata", 64'(exp_rr[0] ? i_rdata : d_rdata), 64'(data));
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    settle();
    chk("rnd_idle_gnt_rr", 64'(gnt), 64'd0);
    chk("rnd_idle_gnt_fx", 64'(f_gnt), 64'd0);
  endtask

  logic        rv_t [9];
  logic        rr_t [9];
  logic        lst_t[9];
  logic [31:0] dat_t[9];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    do_reset();

    // Single I read, length 0
    i_arvalid = 1'b1; i_araddr = 32'h100; i_arlen = 8'd0; i_rready = 1'b1;
    settle();
    chk("s1_idle_gnt", 64'(gnt), 64'd0);
    chk("s1_idle_arvalid", 64'(m_arvalid), 64'd0);
    chk("s1_idle_arready", 64'(i_arready), 64'd0);
    cyc();
    m_arready = 1'b1;
    settle();
    chk("s1_gnt", 64'(gnt), 64'd1);
    chk("s1_arvalid", 64'(m_arvalid), 64'd1);
    chk("s1_araddr", 64'(m_araddr), 64'h100);
    chk("s1_arready", 64'(i_arready), 64'd1);
    cyc();
    i_arvalid = 1'b0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b10; m_rlast = 1'b1;
    settle();
    chk("s1_m_arvalid_data", 64'(m_arvalid), 64'd0);
    chk("s1_rvalid", 64'(i_rvalid), 64'd1);
    chk("s1_d_rvalid", 64'(d_rvalid), 64'd0);
    chk("s1_rdata", 64'(i_rdata), 64'hDEADBEEF);
    chk("s1_rresp", 64'(i_rresp), 64'd2);
    chk("s1_m_rready", 64'(m_rready), 64'd1);
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
    settle();
    chk("s1_end_gnt", 64'(gnt), 64'd0);
    chk("s1_end_err", 64'(err), 64'd0);

    // Both requesters held: round-robin alternates, fixed always serves I
    do_reset();
    i_arvalid = 1'b1; i_araddr = 32'h1000; d_arvalid = 1'b1; d_araddr = 32'h2000;
    i_rready = 1'b1; d_rready = 1'b1;
    settle();
    chk("s2_idle_gnt", 64'(gnt), 64'd0);
    round(2'b01, 32'hA0);
    round(2'b10, 32'hA1);
    round(2'b01, 32'hA2);
    round(2'b10, 32'hA3);
    i_arvalid = 1'b0; d_arvalid = 1'b0;

    // D burst of 4 with memory gaps and requester back-pressure
    do_reset();
    d_arvalid = 1'b1; d_araddr = 32'h200; d_arlen = 8'd3; d_rready = 1'b1;
    cyc();
    m_arready = 1'b1;
    settle();
    chk("s4_gnt", 64'(gnt), 64'd2);
    chk("s4_arlen", 64'(m_arlen), 64'd3);
    chk("s4_d_arready", 64'(d_arready), 64'd1);
    chk("s4_i_arready", 64'(i_arready), 64'd0);
    cyc();
    d_arvalid = 1'b0; m_arready = 1'b0;
    rv_t  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rr_t  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    lst_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    dat_t = '{32'h0, 32'hB0, 32'hB1, 32'hB1, 32'hB1, 32'h0, 32'hB2, 32'hB3, 32'h0};
    for (int k = 0; k < 8; k++) begin
      m_rvalid = rv_t[k]; d_rready = rr_t[k]; m_rlast = lst_t[k]; m_rdata = dat_t[k];
      settle();
      chk($sformatf("s4_m_rready_%0d", k), 64'(m_rready), 64'(rr_t[k]));
      chk($sformatf("s4_d_rvalid_%0d", k), 64'(d_rvalid), 64'(rv_t[k]));
      if (rv_t[k]) chk($sformatf("s4_rdata_%0d", k), 64'(d_rdata), 64'(dat_t[k]));
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    settle();
    chk("s4_end_gnt", 64'(gnt), 64'd0);
    chk("s4_end_err", 64'(err), 64'd0);

    // Early RLAST on beat 2 of a 4-beat burst sets the sticky error
    i_arvalid = 1'b1; i_araddr = 32'h300; i_arlen = 8'd3; i_rready = 1'b1;
    cyc();
    m_arready = 1'b1;
    cyc();
    i_arvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hC0;
    settle();
    chk("s5_b1_err", 64'(err), 64'd0);
    cyc();
    m_rdata = 32'hC1; m_rlast = 1'b1;
    settle();
    chk("s5_b2_err_pre", 64'(err), 64'd0);
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    settle();
    chk("s5_err", 64'(err), 64'd1);
    chk("s5_gnt", 64'(gnt), 64'd0);
    i_arvalid = 1'b1; i_arlen = 8'd0;
    cyc();
    m_arready = 1'b1;
    cyc();
    i_arvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hC2;
    settle();
    chk("s5_clean_rvalid", 64'(i_rvalid), 64'd1);
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    settle();
    chk("s5_err_sticky", 64'(err), 64'd1);
    chk("s5_err_sticky_fx", 64'(f_err), 64'd1);

    // Reset asserted during the first data beat
    i_arvalid = 1'b1; i_araddr = 32'h400; i_arlen = 8'd1;
    cyc();
    m_arready = 1'b1;
    cyc();
    i_arvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hE0;
    settle();
    chk("s6_pre_gnt", 64'(gnt), 64'd1);
    cyc();
    rst = 1'b1;
    settle();
    chk("s6_rst_gnt", 64'(gnt), 64'd0);
    chk("s6_rst_rready", 64'(m_rready), 64'd0);
    chk("s6_rst_rvalid", 64'(i_rvalid), 64'd0);
    chk("s6_rst_err", 64'(err), 64'd0);
    cyc();
    rst = 1'b0; m_rvalid = 1'b0;
    i_arvalid = 1'b1; i_araddr = 32'h500; i_arlen = 8'd0;
    cyc();
    m_arready = 1'b1;
    settle();
    chk("s6_new_gnt", 64'(gnt), 64'd1);
    chk("s6_new_araddr", 64'(m_araddr), 64'h500);
    cyc();
    i_arvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hE1;
    settle();
    chk("s6_new_rdata", 64'(i_rdata), 64'hE1);
    chk("s6_new_rvalid", 64'(i_rvalid), 64'd1);
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    settle();
    chk("s6_new_end_gnt", 64'(gnt), 64'd0);
    chk("s6_new_end_err", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
